// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - multi-cycle ALU with valid/ready handshake and registered result/flags
// Define ULA_MULDIV_EN to build the iterative MUL/DIV/MOD datapath and the CALC state.
module ula_multiciclo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [7:0]       flags,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b1011;
  localparam logic [3:0] OP_XNOR = 4'b1100;

`ifdef ULA_MULDIV_EN
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_MOD = 4'b0101;
  localparam int         CW     = $clog2(WIDTH);

  typedef enum logic [1:0] { IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2 } state_t;
`else
  typedef enum logic [1:0] { IDLE = 2'd0, DONE = 2'd2 } state_t;
`endif

  state_t state;

  // Zero, sign and parity always come from the final result.
  function automatic logic [7:0] make_flags(input logic [WIDTH-1:0] r, input logic carry,
                                            input logic ovf, input logic ill, input logic dz);
    return {dz, ovf, 1'b0, ill, ~^r, r[WIDTH-1], carry, (r == '0)};
  endfunction

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] imm_res;
  logic             imm_carry;
  logic             imm_ovf;
  logic             imm_ill;
  logic             imm_dz;
`ifdef ULA_MULDIV_EN
  logic             start_iter;
`endif

  assign add_full = {1'b0, operand1} + {1'b0, operand2};
  assign sub_full = {1'b0, operand1} - {1'b0, operand2};

  always_comb begin
    imm_res   = '0;
    imm_carry = 1'b0;
    imm_ovf   = 1'b0;
    imm_ill   = 1'b0;
    imm_dz    = 1'b0;
`ifdef ULA_MULDIV_EN
    start_iter = 1'b0;
`endif
    case (op)
      OP_ADD: begin
        imm_res   = add_full[WIDTH-1:0];
        imm_carry = add_full[WIDTH];
        imm_ovf   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                    (add_full[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        imm_res   = sub_full[WIDTH-1:0];
        imm_carry = sub_full[WIDTH];
        imm_ovf   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                    (sub_full[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_AND:  imm_res = operand1 & operand2;
      OP_OR:   imm_res = operand1 | operand2;
      OP_XOR:  imm_res = operand1 ^ operand2;
      OP_NOT:  imm_res = ~operand1;
      OP_NOR:  imm_res = ~(operand1 | operand2);
      OP_NAND: imm_res = ~(operand1 & operand2);
      OP_XNOR: imm_res = ~(operand1 ^ operand2);
`ifdef ULA_MULDIV_EN
      OP_MUL:  start_iter = 1'b1;
      OP_DIV: begin
        if (operand2 == '0) imm_dz = 1'b1;
        else                start_iter = 1'b1;
      end
      OP_MOD: begin
        if (operand2 == '0) begin
          imm_res = operand1;
          imm_dz  = 1'b1;
        end else begin
          start_iter = 1'b1;
        end
      end
`endif
      default: imm_ill = 1'b1;
    endcase
  end

`ifdef ULA_MULDIV_EN
  // hi/lo double as product halves for MUL and remainder/quotient for DIV/MOD.
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd2_r;
  logic [3:0]       op_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic             div_ge;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH-1:0] iter_res;

  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd2_r} : '0);
  assign shifted = {hi, lo[WIDTH-1]};
  assign div_ge  = shifted >= {1'b0, opnd2_r};

  always_comb begin
    if (op_r == OP_MUL) begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end else begin
      // Partial remainder stays below 2*divisor, so the low bits of the difference are exact.
      hi_n = div_ge ? (shifted[WIDTH-1:0] - opnd2_r) : shifted[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], div_ge};
    end
  end

  assign iter_res = (op_r == OP_MOD) ? hi_n : lo_n;
  assign busy     = (state == CALC);
`else
  assign busy     = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      flags  <= '0;
`ifdef ULA_MULDIV_EN
      hi      <= '0;
      lo      <= '0;
      opnd2_r <= '0;
      op_r    <= '0;
      cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef ULA_MULDIV_EN
            if (start_iter) begin
              state   <= CALC;
              hi      <= '0;
              lo      <= operand1;
              opnd2_r <= operand2;
              op_r    <= op;
              cnt     <= CW'(WIDTH - 1);
            end else
`endif
            begin
              state  <= DONE;
              result <= imm_res;
              flags  <= make_flags(imm_res, imm_carry, imm_ovf, imm_ill, imm_dz);
            end
          end
        end
`ifdef ULA_MULDIV_EN
        CALC: begin
          hi <= hi_n;
          lo <= lo_n;
          if (cnt == '0) begin
            state  <= DONE;
            result <= iter_res;
            flags  <= make_flags(iter_res, 1'b0, (op_r == OP_MUL) && (hi_n != '0), 1'b0, 1'b0);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
